// File: rtl/constant_pkg.sv
// Constants shared between the fetch stage and the program loader.
package constant;

  localparam int unsigned INST_SIZE  = 5;
  localparam logic [31:0] END_MARKER = 32'h0000_003F;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling timed from the synchronized start edge.
module uart_rx
  import constant::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLK_PER_HALF_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, ferr_d;

  // Next-state: start re-check at half bit, then one sample per full bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = CNT_START;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync1_q  <= rxd;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_data  <= data_d;
      rx_valid <= valid_d;
      rx_ferr  <= ferr_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a program image from UART into instruction memory, little-endian words,
// stopping after the end marker word has been written.
module program_loader
  import constant::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 rxd,
  output logic                 we,
  output logic [INST_SIZE-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 done,
  output logic                 err
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_uart_rx (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  loader_state_t        state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [INST_SIZE-1:0] addr_q, addr_d;
  logic [31:0]          word_q, word_d;
  logic [INST_SIZE-1:0] waddr_d;
  logic [31:0]          wdata_d;
  logic                 we_d, done_d, err_d;

  // Enable low wins over everything except the sticky error state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
    waddr_d = waddr;
    wdata_d = wdata;
    if (!enable && state_q != LD_ERROR) begin
      state_d = LD_IDLE;
      idx_d   = 2'd0;
      addr_d  = '0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          state_d = LD_RECV;
          idx_d   = 2'd0;
          addr_d  = '0;
        end
        LD_RECV: begin
          if (rx_ferr) begin
            state_d = LD_ERROR;
          end else if (rx_valid) begin
            word_d = {rx_data, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = LD_WRITE;
              waddr_d = addr_q;
              wdata_d = {rx_data, word_q[31:8]};
            end
          end
        end
        LD_WRITE: begin
          if (word_q == END_MARKER) begin
            state_d = LD_DONE;
          end else if (&addr_q) begin
            state_d = LD_ERROR;
          end else begin
            addr_d  = addr_q + INST_SIZE'(1);
            state_d = LD_RECV;
          end
        end
        LD_DONE:  state_d = LD_DONE;
        LD_ERROR: state_d = LD_ERROR;
        default:  state_d = LD_IDLE;
      endcase
    end
    we_d   = (state_d == LD_WRITE);
    done_d = (state_d == LD_DONE);
    err_d  = (state_d == LD_ERROR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LD_IDLE;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      word_q  <= 32'd0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= 32'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      we      <= we_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Receives a program image over the UART RX line in EXEC-independent LOAD phase, packs bytes into 32-bit instructions and writes them sequentially into the instruction BRAM write port consumed by the fetch stage. Loading ends at the end-of-program marker word 32'h0000003F, which is written like any other word. The block then holds `done` high so the top level can switch fetch from LOAD to EXEC.

## Interface
Parameters:
- CLK_PER_HALF_BIT, 434, clock cycles per half UART bit period (115200 baud at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  load permitted while high; low aborts and returns to IDLE.
- rxd  in  1  UART RX, 8N1, idle high, asynchronous to clk.
- we  out  1  instruction-memory write strobe, one-cycle pulse.
- waddr  out  INST_SIZE  word address of the write.
- wdata  out  32  instruction word.
- done  out  1  marker written; held until reset or enable low.
- err  out  1  framing error or address overflow; sticky until reset.

## Operation
- Reset: we=0, waddr=0, wdata=0, done=0, err=0, FSM=IDLE, byte index=0.
- uart_rx:
  - 2-flop synchronizer on rxd.
  - Falling edge of the synchronized rxd starts a frame.
  - Start bit is re-checked at CLK_PER_HALF_BIT. If rxd is high there, the frame is abandoned silently as a glitch.
  - Data bits are sampled every 2*CLK_PER_HALF_BIT thereafter, LSB first.
  - Stop bit sampled 1 → rx_valid pulse with the byte. Stop bit sampled 0 → rx_ferr pulse.
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
  - IDLE: enable=1 → RECV, with byte index=0 and address=0.
  - RECV: each rx_valid stores the byte into the word little-endian (byte 0 → bits[7:0] … byte 3 → bits[31:24]) and increments the byte index. The 4th byte → WRITE.
  - WRITE: one cycle with we=1, waddr=current address, wdata=assembled word. Next state:
    - word==32'h3F → DONE.
    - else, address==2**INST_SIZE-1 → ERROR.
    - else address+1 → RECV.
  - DONE: done=1. Further bytes are ignored.
  - ERROR: err=1, we never asserted. Left only by reset.
- rx_ferr in RECV → ERROR; the partial word is discarded.
- enable low in any state except ERROR → IDLE next cycle:
  - done cleared, byte index and address cleared.
  - A partial word is discarded without a write.
- A byte completing in the same cycle enable falls is discarded.
- waddr/wdata hold their last value when we=0.

## Timing
- uart_rx samples the stop bit 19*CLK_PER_HALF_BIT cycles after the synchronized falling edge. rx_valid asserts the next cycle.
- we asserts the cycle after the 4th rx_valid of a word.
- done rises the cycle after the marker write (we and done never overlap).
- err rises the cycle after rx_ferr or the overflowing write.
- Throughput is bounded by the UART. The FSM is always back in RECV long before the next byte can arrive.
- Asynchronous reset mid-frame: all outputs are 0 immediately and the partial byte is lost.

## Structure
- INST_SIZE comes from the shared package `constant`. Add to it:
  - END_MARKER = 32'h0000003F (shared with fetch's end detection).
  - A loader state enum typedef.
- One sub-module, `uart_rx` (CLK_PER_HALF_BIT parameter; outputs rx_data[7:0], rx_valid, rx_ferr). It is reusable for other serial input.
- `program_loader` drives the INST_BRAM port-A write side directly.

## Test plan
All scenarios use CLK_PER_HALF_BIT=4.
- Reset: hold rstn=0 → we=0, waddr=0, wdata=0, done=0, err=0. Release with rxd=1 and enable=0 → no activity.
- Single word: enable=1, send 78 56 34 12 → one we pulse, waddr=0, wdata=32'h12345678, done=0.
- Full program:
  - Send three words, then 3F 00 00 00 → writes at waddr 0,1,2,3, the last with wdata=32'h3F.
  - done=1 one cycle after the 4th write.
  - Extra bytes afterwards → no we.
- Framing error: after one byte, send a frame with stop bit 0 → err=1, no we. Subsequent valid bytes are still ignored.
- Abort and restart:
  - Drop enable after two bytes → no we.
  - Re-enable, send AA BB CC DD → we with waddr=0, wdata=32'hDDCCBBAA.
- Overflow: send 2**INST_SIZE non-marker words → last write at waddr=2**INST_SIZE-1, then err=1, done=0, no further we.
